i2c_slave_rx: RTL and testbench

- I2C slave receiver (target side, write-only) for the bus driven by our I2C master transmitter.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches the 7-bit address, ACKs matching write transactions and delivers each received data byte on a one-cycle valid strobe.
- Sits at the pad interface. SDA is open-drain: the block only ever pulls SDA low.

---
 rtl/i2c_slave_rx.sv | 131 +++++++++++++
 tb/tb_i2c_slave_rx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_rx.sv
// rtl/i2c_slave_rx.sv - I2C write-only target: START/STOP detect, address match, ACK, byte delivery
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       addr_match,
    output logic       busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ADDR   = 3'd1;
    localparam logic [2:0] ST_ACK_A  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_ACK_D  = 3'd4;
    localparam logic [2:0] ST_IGNORE = 3'd5;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;

    logic [2:0]             state;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift_reg;
    logic [7:0]             shift_next;

    // Idle bus is high, so the synchronizers reset to 1 to avoid a false START on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= {SYNC_STAGES{1'b1}};
            sda_sync <= {SYNC_STAGES{1'b1}};
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    assign scl_s      = scl_sync[SYNC_STAGES-1];
    assign sda_s      = sda_sync[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_prev;
    assign scl_fall   = ~scl_s & scl_prev;
    assign start_det  = scl_s & ~sda_s & sda_prev;
    assign stop_det   = scl_s & sda_s & ~sda_prev;
    assign shift_next = {shift_reg[6:0], sda_s};
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            sda_oe     <= 1'b0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            addr_match <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (start_det) begin
                state      <= ST_ADDR;
                bit_cnt    <= 3'd0;
                sda_oe     <= 1'b0;
                addr_match <= 1'b0;
            end else if (stop_det) begin
                state      <= ST_IDLE;
                bit_cnt    <= 3'd0;
                sda_oe     <= 1'b0;
                addr_match <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= shift_next;
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (shift_next[7:1] == SLAVE_ADDR && !shift_next[0])
                                    state <= ST_ACK_A;
                                else
                                    state <= ST_IGNORE;
                            end
                        end
                    end
                    // sda_oe doubles as the ACK phase flag: first SCL fall drives, second releases.
                    ST_ACK_A, ST_ACK_D: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe     <= 1'b1;
                                addr_match <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                state   <= ST_DATA;
                                bit_cnt <= 3'd0;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (scl_rise) begin
                            shift_reg <= shift_next;
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                data_out   <= shift_next;
                                data_valid <= 1'b1;
                                state      <= ST_ACK_D;
                            end
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// tb/tb_i2c_slave_rx.sv - scoreboard bench for i2c_slave_rx driven by a bit-banged master
module tb_i2c_slave_rx;

    localparam logic [6:0] ADDR = 7'h42;
    localparam int         Q    = 4;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_oe;
    logic [7:0] data_out;
    logic       data_valid;
    logic       addr_match;
    logic       busy;
    logic       sda_line;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] tx_data[$];

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_rx #(
        .SLAVE_ADDR (ADDR),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_m),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .data_out  (data_out),
        .data_valid(data_valid),
        .addr_match(addr_match),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic addr_ok(input logic [7:0] a);
        return (a[7:1] == ADDR) && (a[0] == 1'b0);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(2 * Q);
    endtask

    task automatic send_bit(input logic b, input logic oe_exp, input string name);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(Q);
        check(name, sda_oe, oe_exp);
        tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack_exp);
        for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0, "sda_oe_in_bit");
        send_bit(1'b1, ack_exp, "ack_slot");
    endtask

    task automatic transfer(input logic [7:0] a);
        logic ok;
        ok = addr_ok(a);
        i2c_start();
        check("busy_after_start", busy, 1);
        send_byte(a, ok);
        check("addr_match", addr_match, ok);
        foreach (tx_data[i]) begin
            if (ok) exp_q.push_back(tx_data[i]);
            send_byte(tx_data[i], ok);
            check("busy_in_txn", busy, 1);
        end
        i2c_stop();
        check("busy_after_stop", busy, 0);
        check("addr_match_after_stop", addr_match, 0);
    endtask

    always @(negedge clk) begin
        if (data_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_data_valid", data_out, 32'hFFFF_FFFF);
            end else begin
                check("data_byte", data_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a;
        int         kind;

        tick(3);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_data_out", data_out, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_addr_match", addr_match, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick(8);

        tx_data = '{8'hA5};
        tx_data.push_front(8'hA5);
        tx_data.delete();
        tx_data.push_back(8'hA5);
        transfer(8'h84);
        check("last_byte_a5", data_out, 8'hA5);

        tx_data.delete(); tx_data.push_back(8'h5A);
        transfer(8'h86);

        tx_data.delete(); tx_data.push_back(8'h33);
        transfer(8'h85);

        tx_data.delete();
        tx_data.push_back(8'h12); tx_data.push_back(8'h34); tx_data.push_back(8'hFF);
        transfer(8'h84);

        // Partial byte then repeated START: the four bits must never surface.
        i2c_start();
        send_byte(8'h84, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, "sda_oe_partial");
        i2c_start();
        check("addr_match_after_rstart", addr_match, 0);
        check("busy_after_rstart", busy, 1);
        send_byte(8'h84, 1'b1);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        i2c_stop();
        check("busy_after_rstart_stop", busy, 0);

        // Reset while the slave is holding the ACK low.
        i2c_start();
        for (int i = 7; i >= 0; i--) begin
            a = 8'h84;
            send_bit(a[i], 1'b0, "sda_oe_in_bit");
        end
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        check("ack_before_reset", sda_oe, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_sda_oe", sda_oe, 0);
        check("async_rst_data_out", data_out, 0);
        check("async_rst_addr_match", addr_match, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_data_valid", data_valid, 0);
        tick(3);
        scl_m = 1'b1; sda_m = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(8);
        tx_data.delete(); tx_data.push_back(8'h77);
        transfer(8'h84);
        check("post_reset_byte", data_out, 8'h77);

        for (int t = 0; t < 16; t++) begin
            kind = int'($urandom_range(0, 3));
            case (kind)
                0, 1:    a = 8'h84;
                2:       a = 8'h85;
                default: a = 8'($urandom_range(0, 255));
            endcase
            tx_data.delete();
            for (int k = 0; k < int'($urandom_range(1, 4)); k++)
                tx_data.push_back(8'($urandom_range(0, 255)));
            transfer(a);
        end

        tick(20);
        check("exp_queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
